// File: rtl/line_follow_ctrl.sv
// Rover line-following steering controller: synchronised/debounced sensors driving an H-bridge FSM.
// Optional PWM gating of the motor command is built when LFC_PWM_EN is defined.
module line_follow_ctrl #(
  parameter int unsigned N_SENS       = 5,
  parameter int unsigned DEBOUNCE     = 4,
  parameter int unsigned LOST_TICKS   = 16,
  parameter int unsigned AVOID_TICKS  = 32,
  parameter int unsigned SEARCH_TICKS = 256,
  parameter int unsigned PWM_BITS     = 4,
  parameter int unsigned PWM_DUTY     = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_SENS-1:0] induct,
  input  logic              proxim,
  output logic [3:0]        motor_in,
  output logic [2:0]        state_o
);

  localparam int unsigned NB       = N_SENS + 1;
  localparam int unsigned CENTRE   = N_SENS / 2;
  localparam int unsigned CNT_W    = $clog2(N_SENS + 1);
  localparam int unsigned DB_W     = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int unsigned LOST_W   = (LOST_TICKS > 1) ? $clog2(LOST_TICKS) : 1;
  localparam int unsigned AVOID_W  = (AVOID_TICKS > 1) ? $clog2(AVOID_TICKS) : 1;
  localparam int unsigned SEARCH_W = (SEARCH_TICKS > 1) ? $clog2(SEARCH_TICKS) : 1;

  localparam logic [3:0] CMD_FWD   = 4'b0110;
  localparam logic [3:0] CMD_LEFT  = 4'b1010;
  localparam logic [3:0] CMD_RIGHT = 4'b0101;
  localparam logic [3:0] CMD_STOP  = 4'b0000;

  typedef enum logic [2:0] {
    ST_FOLLOW = 3'd0,
    ST_OBST   = 3'd1,
    ST_CLEAR  = 3'd2,
    ST_SEARCH = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  if ((N_SENS % 2 == 0) || (N_SENS < 3) || (DEBOUNCE < 1) || (LOST_TICKS < 1) ||
      (AVOID_TICKS < 1) || (SEARCH_TICKS < 1) || (PWM_BITS < 1) ||
      (PWM_DUTY > (1 << PWM_BITS))) begin : g_cfg_err
    $error("line_follow_ctrl: illegal parameter set");
  end

  // Proxim rides along as the top bit so one sync/debounce path serves every input.
  logic [NB-1:0]   raw, sync1, sync2, db;
  logic [DB_W-1:0] db_cnt [NB];

  assign raw = {proxim, induct};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // A bit flips only after DEBOUNCE consecutive synchronised samples disagree with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      db <= '0;
      for (int unsigned i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE - 1)) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  logic [N_SENS-1:0] line_db;
  logic              prox_db, any_line, all_line;
  logic [CNT_W-1:0]  lc, rc;

  assign line_db  = db[N_SENS-1:0];
  assign prox_db  = db[N_SENS];
  assign any_line = |line_db;
  assign all_line = &line_db;

  always_comb begin
    lc = '0;
    rc = '0;
    for (int unsigned i = 0; i < N_SENS; i++) begin
      if (i < CENTRE)      lc = lc + CNT_W'(line_db[i]);
      else if (i > CENTRE) rc = rc + CNT_W'(line_db[i]);
    end
  end

  state_t              state_q, state_d;
  logic [3:0]          cmd_q, cmd_d, fol_cmd, search_cmd;
  logic                dir_q, dir_d, fol_dir;   // dir: 0 = left, 1 = right
  logic [LOST_W-1:0]   lost_q, lost_d;
  logic [AVOID_W-1:0]  avoid_q, avoid_d;
  logic [SEARCH_W-1:0] search_q, search_d;

  assign search_cmd = dir_q ? CMD_RIGHT : CMD_LEFT;

  // Steering decision while a line is visible; an intersection keeps the old command.
  always_comb begin
    fol_cmd = cmd_q;
    fol_dir = dir_q;
    if (!all_line) begin
      if (lc > rc) begin
        fol_cmd = CMD_LEFT;
        fol_dir = 1'b0;
      end else if (rc > lc) begin
        fol_cmd = CMD_RIGHT;
        fol_dir = 1'b1;
      end else if (any_line) begin
        fol_cmd = CMD_FWD;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    dir_d    = dir_q;
    lost_d   = lost_q;
    avoid_d  = avoid_q;
    search_d = search_q;
    if (prox_db) begin
      state_d = ST_OBST;
      cmd_d   = CMD_LEFT;
    end else begin
      case (state_q)
        ST_FOLLOW: begin
          if (any_line) begin
            cmd_d  = fol_cmd;
            dir_d  = fol_dir;
            lost_d = '0;
          end else if (lost_q == LOST_W'(LOST_TICKS - 1)) begin
            state_d  = ST_SEARCH;
            search_d = '0;
            cmd_d    = search_cmd;
          end else if (lost_q != '1) begin
            lost_d = lost_q + LOST_W'(1);
          end
        end
        ST_OBST: begin
          state_d = ST_CLEAR;
          avoid_d = '0;
          cmd_d   = CMD_FWD;
        end
        ST_CLEAR: begin
          cmd_d = CMD_FWD;
          if (avoid_q == AVOID_W'(AVOID_TICKS - 1)) begin
            state_d = ST_FOLLOW;
            lost_d  = '0;
          end else if (avoid_q != '1) begin
            avoid_d = avoid_q + AVOID_W'(1);
          end
        end
        ST_SEARCH: begin
          if (any_line) begin
            state_d = ST_FOLLOW;
            lost_d  = '0;
            cmd_d   = fol_cmd;
            dir_d   = fol_dir;
          end else if (search_q == SEARCH_W'(SEARCH_TICKS - 1)) begin
            state_d = ST_HALT;
            cmd_d   = CMD_STOP;
          end else begin
            cmd_d = search_cmd;
            if (search_q != '1) search_d = search_q + SEARCH_W'(1);
          end
        end
        ST_HALT: begin
          if (any_line) begin
            state_d = ST_FOLLOW;
            lost_d  = '0;
            cmd_d   = fol_cmd;
            dir_d   = fol_dir;
          end else begin
            cmd_d = CMD_STOP;
          end
        end
        default: begin
          state_d = ST_FOLLOW;
          cmd_d   = CMD_STOP;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FOLLOW;
      cmd_q    <= CMD_STOP;
      dir_q    <= 1'b0;
      lost_q   <= '0;
      avoid_q  <= '0;
      search_q <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      dir_q    <= dir_d;
      lost_q   <= lost_d;
      avoid_q  <= avoid_d;
      search_q <= search_d;
    end
  end

  assign state_o = state_q;

`ifdef LFC_PWM_EN
  localparam int unsigned PWM_W = PWM_BITS + 1;

  logic [PWM_BITS-1:0] pwm_q;
  logic [3:0]          motor_q;

  // The held command passes only during the on-portion of each PWM period.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_q   <= '0;
      motor_q <= CMD_STOP;
    end else begin
      pwm_q   <= pwm_q + PWM_BITS'(1);
      motor_q <= ({1'b0, pwm_q} < PWM_W'(PWM_DUTY)) ? cmd_d : CMD_STOP;
    end
  end

  assign motor_in = motor_q;
`else
  assign motor_in = cmd_q;
`endif

endmodule
